// File: rtl/data_mem_responder_pkg.sv
// data_mem_pkg: shared states, region codes and widths for the data-memory responder.
package data_mem_pkg;
    localparam int WORD_W = 16;
    localparam int LED_W = 9;
    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_SW = 4'h3;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: processor-side Req/Ack data-memory bus.
interface data_mem_responder_if;
    import data_mem_pkg::*;
    logic Req;
    logic W;
    logic [WORD_W-1:0] ADDR;
    logic [WORD_W-1:0] DOUT;
    logic Ready;
    logic Ack;
    logic [WORD_W-1:0] DATA;
    modport master (output Req, W, ADDR, DOUT, input Ready, Ack, DATA);
    modport slave (input Req, W, ADDR, DOUT, output Ready, Ack, DATA);
endinterface

// File: rtl/data_mem_responder_ram_sync.sv
// ram_sync: single-port word RAM with one write enable and a registered read.
module ram_sync #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: Req/Ack data-memory responder with wait states, RAM, LED register and switch inputs.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    data_mem_responder_if.slave bus,
    input  logic [LED_W-1:0]  SW,
    output logic [LED_W-1:0]  LEDR
);
    localparam logic [3:0] WS = WAIT_STATES[3:0];
    state_t state, nxt;
    logic [3:0] cnt;
    logic [3:0] region_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [WORD_W-1:0] dout_q;
    logic w_q;
    logic [LED_W-1:0] sw_meta, sw_sync;
    logic [WORD_W-1:0] io_q, data_q, ram_q, rd_val;
    logic ram_we;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = IDLE;
        nxt = (state == IDLE) ? (bus.Req ? ((WS == 4'd0) ? ACCESS : WAIT) : IDLE)
            : (state == WAIT) ? ((cnt <= 4'd1) ? ACCESS : WAIT)
            : (state == ACCESS) ? RESP : IDLE;
    end
    assign bus.Ready = (state == IDLE);
    assign bus.Ack = (state == RESP);
    assign ram_we = (state == ACCESS) && w_q && (region_q == REG_RAM);
    // RAM data arrives from its output register; IO data was captured at the same ACCESS edge
    assign rd_val = (region_q == REG_RAM) ? ram_q : io_q;
    assign bus.DATA = ((state == RESP) && !w_q) ? rd_val : data_q;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            region_q <= '0;
            idx_q <= '0;
            dout_q <= '0;
            w_q <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
            io_q <= '0;
            data_q <= '0;
            LEDR <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (state == IDLE && bus.Req) begin
                region_q <= bus.ADDR[15:12];
                idx_q <= bus.ADDR[ADDR_WIDTH-1:0];
                dout_q <= bus.DOUT;
                w_q <= bus.W;
                cnt <= WS;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS) begin
                if (w_q && region_q == REG_LED) LEDR <= dout_q[LED_W-1:0];
                io_q <= (region_q == REG_LED) ? {{(WORD_W-LED_W){1'b0}}, LEDR}
                      : (region_q == REG_SW) ? {{(WORD_W-LED_W){1'b0}}, sw_sync}
                      : '0;
            end
            if (state == RESP && !w_q) data_q <= rd_val;
        end
    end
    ram_sync #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WORD_W)) u_ram (
        .clk(Clock),
        .we(ram_we),
        .addr(idx_q),
        .wdata(dout_q),
        .rdata(ram_q)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed checks of two responders (WAIT_STATES=1 and 0) against a memory model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic req = 1'b0;
    logic w = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] dout = '0;
    logic [8:0] sw = '0;
    logic [8:0] ledr_a, ledr_b;
    logic ready_o, ack_o;
    logic [15:0] data_o;
    logic [8:0] ledr_o;
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] ref_mem [2][256];
    logic [8:0] ref_led [2];
    logic [15:0] ref_data [2];
    logic [8:0] sw_val = '0;
    data_mem_responder_if ifa ();
    data_mem_responder_if ifb ();
    assign ifa.Req = req & ~sel;
    assign ifb.Req = req & sel;
    assign ifa.W = w;
    assign ifb.W = w;
    assign ifa.ADDR = addr;
    assign ifb.ADDR = addr;
    assign ifa.DOUT = dout;
    assign ifb.DOUT = dout;
    assign ready_o = sel ? ifb.Ready : ifa.Ready;
    assign ack_o = sel ? ifb.Ack : ifa.Ack;
    assign data_o = sel ? ifb.DATA : ifa.DATA;
    assign ledr_o = sel ? ledr_b : ledr_a;
    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut_a (
        .Clock(clk), .Reset(rst), .bus(ifa), .SW(sw), .LEDR(ledr_a)
    );
    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
        .Clock(clk), .Reset(rst), .bus(ifb), .SW(sw), .LEDR(ledr_b)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s dut=%0d got=%h want=%h t=%0t", tag, sel, obs, exp, $time);
        end
    endtask
    function automatic logic [15:0] exp_load(input bit s, input logic [15:0] a);
        case (a[15:12])
            4'h0: return ref_mem[s][a[7:0]];
            4'h1: return {7'b0, ref_led[s]};
            4'h3: return {7'b0, sw_val};
            default: return 16'h0000;
        endcase
    endfunction
    task automatic model_store(input bit s, input logic [15:0] a, input logic [15:0] d);
        if (a[15:12] == 4'h0) ref_mem[s][a[7:0]] = d;
        else if (a[15:12] == 4'h1) ref_led[s] = d[8:0];
    endtask
    task automatic op(input bit s, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int lat;
        bit busy_ok;
        logic [15:0] exp;
        exp = exp_load(s, a);
        sel = s;
        w = wr;
        addr = a;
        dout = d;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!ack_o && lat < 40) begin
            busy_ok &= !ready_o;
            @(posedge clk);
            #1 lat++;
        end
        chk("ack_latency", lat, s ? 2 : 3);
        chk("ready_low_busy", {31'b0, busy_ok}, 1);
        if (wr) begin
            model_store(s, a, d);
            chk("store_keeps_data", data_o, ref_data[s]);
        end else begin
            ref_data[s] = exp;
            chk("load_data", data_o, exp);
        end
        @(posedge clk);
        #1;
        chk("ack_one_cycle", {31'b0, ack_o}, 0);
        chk("ready_idle", {31'b0, ready_o}, 1);
        chk("ledr", {23'b0, ledr_o}, {23'b0, ref_led[s]});
        chk("data_hold", data_o, ref_data[s]);
    endtask
    task automatic set_sw(input logic [8:0] v);
        sw = v;
        sw_val = v;
        repeat (3) @(posedge clk);
        #1;
    endtask
    initial begin
        int acks;
        logic [3:0] regs [9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h7, 4'h2, 4'hF};
        logic [15:0] a;
        for (int s = 0; s < 2; s++) begin
            ref_led[s] = '0;
            ref_data[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_ready", {31'b0, ready_o}, 1);
            chk("rst_ack", {31'b0, ack_o}, 0);
            chk("rst_data", data_o, 16'h0000);
            chk("rst_ledr", {23'b0, ledr_o}, 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) op(s[0], 1'b1, 16'(i), 16'($urandom));
        op(0, 1, 16'h0005, 16'hBEEF);
        op(0, 0, 16'h0005, 16'h0);
        op(0, 1, 16'h1000, 16'h01A5);
        op(0, 0, 16'h1000, 16'h0);
        set_sw(9'h0F0);
        op(0, 0, 16'h3000, 16'h0);
        op(0, 1, 16'h3000, 16'hFFFF);
        op(0, 0, 16'h7000, 16'h0);
        op(0, 1, 16'h0105, 16'h5A5A);
        op(0, 0, 16'h0005, 16'h0);
        op(1, 1, 16'h0003, 16'hC0DE);
        op(1, 0, 16'h0003, 16'h0);
        op(1, 0, 16'h3000, 16'h0);
        // a second Req held through WAIT must not start another access
        sel = 1'b0;
        w = 1'b0;
        addr = 16'h0005;
        req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 req = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 acks += int'(ack_o);
        end
        ref_data[0] = exp_load(0, 16'h0005);
        chk("single_ack", acks, 1);
        chk("req_in_wait_data", data_o, ref_data[0]);
        // reset while a store sits in WAIT abandons the write
        op(0, 1, 16'h0009, 16'h5555);
        op(0, 0, 16'h1000, 16'h0);
        sel = 1'b0;
        w = 1'b1;
        addr = 16'h0009;
        dout = 16'h1234;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_ack", {31'b0, ack_o}, 0);
        chk("midrst_data", data_o, 16'h0000);
        chk("midrst_ready", {31'b0, ready_o}, 1);
        chk("midrst_ledr", {23'b0, ledr_o}, 0);
        for (int s = 0; s < 2; s++) begin
            ref_led[s] = '0;
            ref_data[s] = '0;
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        op(0, 0, 16'h0009, 16'h0);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_sw(9'($urandom));
            end else begin
                a = {regs[$urandom_range(0, 8)], 12'($urandom)};
                if (a[15:12] == 4'h0) a = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
                op(1'($urandom), 1'($urandom), a, 16'($urandom));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
